serial_word_loader: RTL and testbench
=====================================

# serial_word_loader

Serial-to-parallel loader that assembles a single-bit input stream into WIDTH-bit words and presents each word, with a valid/ready handshake, to the 32-bit D-register stage (`d_out` drives that stage's `D`). A shift register plus an output holding register (double buffering) let the next word fill while the current one waits. Backpressure reaches the serial side only when both buffers are full.

## Interface
- `WIDTH`, 32: word width; legal range ≥2.
- `MSB_FIRST`, 1: 1 = first received bit lands in `d_out[WIDTH-1]`; 0 = first bit lands in `d_out[0]`.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `sin`  in  1: serial data bit.
- `sin_valid`  in  1: `sin` is valid this cycle.
- `sin_ready`  out  1: loader accepts a bit this cycle.
- `sync`  in  1: word-boundary marker; restarts word assembly.
- `d_out`  out  WIDTH: assembled word.
- `d_valid`  out  1: `d_out` holds an unconsumed word.
- `d_ready`  in  1: consumer accepts `d_out` this cycle.
- `bit_cnt`  out  $clog2(WIDTH): bits collected in the current partial word.
- `ovf`  out  1: sticky flag; a bit was offered while `sin_ready` was 0.

## Operation
- Internal state: shift register `sr[WIDTH-1:0]`, counter `bit_cnt`, FSM {FILL, FULL}.
- Reset (edge with `rst`=1): state FILL, `sr`=0, `bit_cnt`=0, `d_out`=0, `d_valid`=0, `ovf`=0. `sin_ready` = (state==FILL) && !rst, so it is 0 while `rst` is high.
- Bit accept: `sin_valid && sin_ready`.
  - MSB_FIRST=1: `sr <= {sr[WIDTH-2:0], sin}`.
  - MSB_FIRST=0: `sr <= {sin, sr[WIDTH-1:1]}`.
  - `bit_cnt` increments.
- Word complete: accept with `bit_cnt==WIDTH-1`; `bit_cnt` wraps to 0.
  - If output register is free (`!d_valid`, or `d_valid && d_ready` this cycle): the new word goes to `d_out`, `d_valid`=1, state stays FILL.
  - Otherwise: the completed word stays in `sr` and state becomes FULL.
- FULL: `sin_ready`=0. On an edge with `d_ready`=1, `sr` moves to `d_out`, `d_valid` stays 1, and state returns to FILL.
- Consume with no replacement word (`d_valid && d_ready`, nothing completing): `d_valid` clears.
- `sync` in FILL: discard the partial word (`bit_cnt`=0). If an accepted bit arrives in the same cycle, it becomes bit 0 of the new word (`bit_cnt`=1). `sync` in FULL is ignored, so a complete word is never discarded. `sync` never affects `d_out` or `d_valid`.
- `ovf` sets on any edge with `sin_valid && !sin_ready && !rst`; the bit is dropped. Only `rst` clears it.

## Timing
- Latency: `d_valid` rises the cycle after the edge that accepts the final bit.
- `d_out` stays stable while `d_valid && !d_ready`.
- Sustained throughput with `d_ready` held at 1 is 1 bit/cycle. There are no stall cycles between words.
- Worst-case stall: at most 1 complete word in `sr` while waiting. `sin_ready` returns to 1 the cycle after the edge where `d_ready` is sampled high in FULL.
- `d_ready` asserted while `d_valid`=0 has no effect.
- `rst` mid-word or mid-FULL drops all buffered data. All outputs take their reset values the cycle after the reset edge.

## Test plan
- Single word, WIDTH=32, MSB_FIRST=1, `d_ready`=1: shift bits of 0xA5A50F0F, MSB first, 32 consecutive cycles -> `d_out`=0xA5A50F0F and `d_valid`=1 one cycle after the 32nd accept, for exactly 1 cycle; `ovf`=0.
- Back-to-back, `d_ready`=1: 64 continuous bits forming 0x00000001 then 0xFFFFFFFF -> `sin_ready` never drops; `d_out`=0x00000001 at cycle 33, then 0xFFFFFFFF at cycle 65.
- Backpressure: `d_ready`=0; send 0x12345678 then 0x9ABCDEF0 -> after the 64th bit, state FULL and `sin_ready`=0; one extra `sin_valid` sets `ovf`=1. Raise `d_ready` for 1 cycle -> `d_out`=0x9ABCDEF0, `d_valid`=1, and `sin_ready`=1 the next cycle.
- Sync: send 10 bits, then `sync`=1 with an accepted bit, then 31 bits of a word -> `bit_cnt`=1 after the sync cycle; the output word equals the 32 bits starting at the sync bit.
- LSB-first (MSB_FIRST=0): send 0x0000000F, LSB first -> `d_out`=0x0000000F.
- Reset mid-word: assert `rst` after 17 bits with `d_valid`=1 -> next cycle `d_out`=0, `d_valid`=0, `bit_cnt`=0, `ovf`=0, `sin_ready`=1; a fresh 32-bit word then assembles correctly.

Source files
------------

// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles a serial bit stream into WIDTH-bit words behind a valid/ready output.
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_sin        serial data bit
//   i_sin_valid  i_sin is valid this cycle
//   o_sin_ready  loader accepts a bit this cycle
//   i_sync       word-boundary marker, restarts assembly of the partial word
//   o_d_out      assembled word (holding register)
//   o_d_valid    o_d_out holds an unconsumed word
//   i_d_ready    consumer accepts o_d_out this cycle
//   o_bit_cnt    bits collected in the current partial word
//   o_ovf        sticky: a bit was offered while o_sin_ready was low
module serial_word_loader #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sin,
    input  logic                     i_sin_valid,
    output logic                     o_sin_ready,
    input  logic                     i_sync,
    output logic [WIDTH-1:0]         o_d_out,
    output logic                     o_d_valid,
    input  logic                     i_d_ready,
    output logic [$clog2(WIDTH)-1:0] o_bit_cnt,
    output logic                     o_ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {FILL, FULL} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_d_out;
    logic             r_d_valid;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic             w_free;
    logic [CW-1:0]    w_cnt_base;
    logic [WIDTH-1:0] w_next_sr;
    assign o_sin_ready = (r_state == FILL) && !i_rst;
    assign w_accept    = i_sin_valid && o_sin_ready;
    // a sync bit starts a fresh word, so counting restarts from zero in that cycle
    assign w_cnt_base  = i_sync ? '0 : r_bit_cnt;
    assign w_last      = w_accept && (w_cnt_base == CW'(WIDTH - 1));
    assign w_free      = !r_d_valid || i_d_ready;
    assign w_next_sr   = MSB_FIRST ? {r_sr[WIDTH-2:0], i_sin} : {i_sin, r_sr[WIDTH-1:1]};
    assign o_d_out     = r_d_out;
    assign o_d_valid   = r_d_valid;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_ovf       = r_ovf;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= FILL;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_d_out   <= '0;
            r_d_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (i_sin_valid && !o_sin_ready)
                r_ovf <= 1'b1;
            if (r_state == FILL) begin
                if (w_accept) begin
                    r_sr      <= w_next_sr;
                    r_bit_cnt <= w_last ? '0 : w_cnt_base + 1'b1;
                end else if (i_sync) begin
                    r_bit_cnt <= '0;
                end
                if (w_last) begin
                    if (w_free) begin
                        r_d_out   <= w_next_sr;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_state <= FULL;
                    end
                end else if (r_d_valid && i_d_ready) begin
                    r_d_valid <= 1'b0;
                end
            end else if (i_d_ready) begin
                // the parked word replaces the consumed one, so d_valid stays high
                r_d_out <= r_sr;
                r_state <= FILL;
            end
        end
    end
endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: directed scoreboard bench for serial_word_loader.
module tb_serial_word_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sin = 1'b0;
    logic        sin_valid = 1'b0;
    logic        sync = 1'b0;
    logic        d_ready = 1'b0;
    logic        sin_ready, d_valid, ovf;
    logic [31:0] d_out;
    logic [4:0]  bit_cnt;
    logic        sin_ready_l, d_valid_l, ovf_l;
    logic [31:0] d_out_l;
    logic [4:0]  bit_cnt_l;
    logic [31:0] q[$];
    logic [31:0] exp_word;
    int          total = 0;
    int          passed = 0;
    bit          stall_seen = 1'b0;

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_sin_valid(sin_valid),
        .o_sin_ready(sin_ready), .i_sync(sync), .o_d_out(d_out),
        .o_d_valid(d_valid), .i_d_ready(d_ready), .o_bit_cnt(bit_cnt), .o_ovf(ovf)
    );

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_sin_valid(sin_valid),
        .o_sin_ready(sin_ready_l), .i_sync(sync), .o_d_out(d_out_l),
        .o_d_valid(d_valid_l), .i_d_ready(d_ready), .o_bit_cnt(bit_cnt_l), .o_ovf(ovf_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [31:0] w, input int hi, input bit push);
        for (int i = hi; i >= 0; i--) begin
            sin = w[i];
            sin_valid = 1'b1;
            if (!sin_ready) stall_seen = 1'b1;
            tick();
        end
        if (push) q.push_back(w);
    endtask

    // consumption monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && d_valid && d_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_word", d_out, 32'hxxxxxxxx);
            end else begin
                exp_word = q.pop_front();
                check("sb_word", d_out, exp_word);
            end
        end
    end

    initial begin
        tick();
        tick();
        check("rst_sin_ready_low", {31'b0, sin_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_d_out", d_out, 32'd0);
        check("rst_d_valid", {31'b0, d_valid}, 32'd0);
        check("rst_bit_cnt", {27'b0, bit_cnt}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_sin_ready", {31'b0, sin_ready}, 32'd1);
        check("rst_lsb_outs", {d_out_l[27:0], bit_cnt_l[0], ovf_l, d_valid_l, sin_ready_l}, 32'd1);

        d_ready = 1'b1;
        send_range(32'hA5A50F0F, 31, 1'b1);
        sin_valid = 1'b0;
        check("single_d_valid", {31'b0, d_valid}, 32'd1);
        check("single_d_out", d_out, 32'hA5A50F0F);
        check("single_ovf", {31'b0, ovf}, 32'd0);
        tick();
        check("single_one_cycle", {31'b0, d_valid}, 32'd0);

        stall_seen = 1'b0;
        send_range(32'h00000001, 31, 1'b1);
        check("b2b_first", d_out, 32'h00000001);
        send_range(32'hFFFFFFFF, 31, 1'b1);
        sin_valid = 1'b0;
        check("b2b_second", d_out, 32'hFFFFFFFF);
        check("b2b_no_stall", {31'b0, stall_seen}, 32'd0);
        tick();
        check("b2b_drained", {31'b0, d_valid}, 32'd0);

        d_ready = 1'b0;
        send_range(32'h12345678, 31, 1'b1);
        check("bp_first_held", d_out, 32'h12345678);
        send_range(32'h9ABCDEF0, 31, 1'b1);
        sin_valid = 1'b0;
        check("bp_full_sin_ready", {31'b0, sin_ready}, 32'd0);
        check("bp_d_out_stable", d_out, 32'h12345678);
        check("bp_bit_cnt", {27'b0, bit_cnt}, 32'd0);
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        check("bp_ovf", {31'b0, ovf}, 32'd1);
        d_ready = 1'b1;
        tick();
        check("bp_second_out", d_out, 32'h9ABCDEF0);
        check("bp_second_valid", {31'b0, d_valid}, 32'd1);
        check("bp_sin_ready_back", {31'b0, sin_ready}, 32'd1);
        tick();
        check("bp_drained", {31'b0, d_valid}, 32'd0);

        send_range(32'h000002B3, 9, 1'b0);
        sin = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_bit_cnt", {27'b0, bit_cnt}, 32'd1);
        send_range(32'h5EC01D3B, 30, 1'b1);
        sin_valid = 1'b0;
        check("sync_word", d_out, 32'h5EC01D3B);
        tick();

        // 0x0000000F sent LSB first; the MSB-first instance sees 0xF0000000
        send_range(32'hF0000000, 31, 1'b1);
        sin_valid = 1'b0;
        check("lsb_first_word", d_out_l, 32'h0000000F);
        check("lsb_first_valid", {31'b0, d_valid_l}, 32'd1);
        check("msb_view_word", d_out, 32'hF0000000);
        tick();

        d_ready = 1'b0;
        send_range(32'h13579BDF, 31, 1'b0);
        send_range(32'h0001FFFF, 16, 1'b0);
        sin_valid = 1'b0;
        check("mid_pre_valid", {31'b0, d_valid}, 32'd1);
        check("mid_pre_cnt", {27'b0, bit_cnt}, 32'd17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_d_out", d_out, 32'd0);
        check("mid_rst_d_valid", {31'b0, d_valid}, 32'd0);
        check("mid_rst_bit_cnt", {27'b0, bit_cnt}, 32'd0);
        check("mid_rst_ovf", {31'b0, ovf}, 32'd0);
        check("mid_rst_sin_ready", {31'b0, sin_ready}, 32'd1);
        d_ready = 1'b1;
        send_range(32'hC3C35A5A, 31, 1'b1);
        sin_valid = 1'b0;
        check("post_rst_word", d_out, 32'hC3C35A5A);
        tick();
        tick();
        check("sb_all_consumed", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
